// File: rtl/pc_unit_pkg.sv
// Shared fetch/control constants for the program counter unit.
// Also holds the next-PC source encoding and its priority resolver.
package pc_unit_pkg;

  localparam int          PC_WIDTH     = 16;
  localparam int          PC_STEP      = 2;
  localparam logic [15:0] PC_RESET_VEC = 16'h0000;
  localparam logic [15:0] PC_EXC_VEC   = 16'h0002;
  localparam int          PC_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SRC_INC    = 3'd0,
    SRC_HOLD   = 3'd1,
    SRC_TARGET = 3'd2,
    SRC_EXC    = 3'd3,
    SRC_EPC    = 3'd4,
    SRC_RAS    = 3'd5
  } pc_src_e;

  // Priority: exc > rti > redirect > stall > pop > increment.
  // A pop that finds the stack empty falls back to the increment.
  function automatic pc_src_e pick_src(input logic exc, input logic rti,
                                       input logic redirect, input logic stall,
                                       input logic pop, input logic ras_empty);
    pc_src_e src;
    src = SRC_INC;
    if (exc)                    src = SRC_EXC;
    else if (rti)               src = SRC_EPC;
    else if (redirect)          src = SRC_TARGET;
    else if (stall)             src = SRC_HOLD;
    else if (pop && !ras_empty) src = SRC_RAS;
    return src;
  endfunction

endpackage

// File: rtl/pc_dff.sv
// Single-bit flop with asynchronous active-high reset to a per-instance value.
module pc_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with write pointer and occupancy count.
// Pushing when full overwrites the oldest entry; misuse sets a sticky error.
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic [PW-1:0]    w_top_idx;
  logic             w_do_pop;
  logic             w_ovf;
  logic             w_unf;

  // r_wptr names the next free slot, so the newest entry sits one below it.
  assign w_top_idx = r_wptr - 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_err     = r_err;

  assign w_do_pop  = i_pop && !i_push && !o_empty;
  assign w_ovf     = i_push && o_full;
  assign w_unf     = i_pop && !i_push && o_empty;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + 1'b1;
        if (!o_full) r_count <= r_count + 1'b1;
      end else if (w_do_pop) begin
        r_wptr  <= r_wptr - 1'b1;
        r_count <= r_count - 1'b1;
      end
      if (w_ovf || w_unf) r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with exception save/restore and a call/return stack.
// pc and epc are flop arrays; next-PC is a priority-resolved mux.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter int               STEP      = PC_STEP,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int               RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  input  logic             push,
  input  logic             pop,
  input  logic             exc,
  input  logic             rti,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  pc_src_e          w_src;
  logic [WIDTH-1:0] w_pc_d;
  logic [WIDTH-1:0] w_epc_d;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_push;
  logic             w_ras_pop;

  assign pc_inc = pc + WIDTH'(STEP);
  assign w_src  = pick_src(exc, rti, redirect, stall, pop, ras_empty);

  // Push rides only on a winning redirect; pop only when nothing above it wins.
  assign w_ras_push = redirect && push && !exc && !rti;
  assign w_ras_pop  = pop && !exc && !rti && !redirect && !stall;

  always_comb begin
    w_pc_d = pc_inc;
    case (w_src)
      SRC_EXC:    w_pc_d = EXC_VEC;
      SRC_EPC:    w_pc_d = epc;
      SRC_TARGET: w_pc_d = target;
      SRC_HOLD:   w_pc_d = pc;
      SRC_RAS:    w_pc_d = w_ras_top;
      default:    w_pc_d = pc_inc;
    endcase
  end

  assign w_epc_d = exc ? pc : epc;

  for (genvar i = 0; i < WIDTH; i++) begin : g_regs
    pc_dff #(.RST_VAL(RESET_VEC[i])) u_pc_bit (
      .clk (clk),
      .rst (rst),
      .d   (w_pc_d[i]),
      .q   (pc[i])
    );
    pc_dff #(.RST_VAL(1'b0)) u_epc_bit (
      .clk (clk),
      .rst (rst),
      .d   (w_epc_d[i]),
      .q   (epc[i])
    );
  end

  pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (pc_inc),
    .o_top   (w_ras_top),
    .o_empty (ras_empty),
    .o_full  (ras_full),
    .o_err   (ras_err)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a queue model.
module tb_pc_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall, redirect, push, pop, exc, rti;
  logic [W-1:0] target;
  logic [W-1:0] pc, pc_inc, epc;
  logic         ras_empty, ras_full, ras_err;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_pc, m_epc;
  logic [W-1:0] m_ras[$];
  logic         m_err;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .redirect  (redirect),
    .target    (target),
    .push      (push),
    .pop       (pop),
    .exc       (exc),
    .rti       (rti),
    .pc        (pc),
    .pc_inc    (pc_inc),
    .epc       (epc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_epc = 16'h0000;
    m_ras.delete();
    m_err = 1'b0;
  endtask

  // Applies one cycle of requests, advances the model, returns 1ns after the edge.
  task automatic drive(input logic s, input logic r, input logic [W-1:0] t,
                       input logic pu, input logic po, input logic e, input logic ri);
    stall = s; redirect = r; target = t; push = pu; pop = po; exc = e; rti = ri;
    if (e) begin
      m_epc = m_pc;
      m_pc  = 16'h0002;
    end else if (ri) begin
      m_pc = m_epc;
    end else if (r) begin
      if (pu) begin
        m_ras.push_back(m_pc + 16'd2);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
      end
      m_pc = t;
    end else if (s) begin
      m_pc = m_pc;
    end else if (po) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc  = m_pc + 16'd2;
        m_err = 1'b1;
      end
    end else begin
      m_pc = m_pc + 16'd2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 0; redirect = 0; target = '0; push = 0; pop = 0; exc = 0; rti = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h want 0000", pc); end
    checks++;
    if (epc !== 16'h0000) begin failures++; $display("FAIL reset_epc: got %h want 0000", epc); end
    checks++;
    if ({ras_empty, ras_full, ras_err} !== 3'b100)
      begin failures++; $display("FAIL reset_flags: got %b want 100", {ras_empty, ras_full, ras_err}); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    logic [W-1:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      idle();
      exp_pc = 16'(i * 2);
      checks++;
      if (pc !== exp_pc) begin failures++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc); end
    end
    checks++;
    if (ras_empty !== 1'b1) begin failures++; $display("FAIL seq_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_call_return();
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0100) begin failures++; $display("FAIL call_pc: got %h want 0100", pc); end
    checks++;
    if (ras_empty !== 1'b0) begin failures++; $display("FAIL call_nonempty: got %b want 0", ras_empty); end
    idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0012) begin failures++; $display("FAIL ret_pc: got %h want 0012", pc); end
    checks++;
    if (ras_empty !== 1'b1) begin failures++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_exception();
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pc !== 16'h0002) begin failures++; $display("FAIL exc_pc: got %h want 0002", pc); end
    checks++;
    if (epc !== 16'h0040) begin failures++; $display("FAIL exc_epc: got %h want 0040", epc); end
    checks++;
    if (ras_empty !== 1'b1) begin failures++; $display("FAIL exc_ras: got %b want 1", ras_empty); end
    idle();
    drive(1'b0, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pc !== 16'h0040) begin failures++; $display("FAIL rti_pc: got %h want 0040", pc); end
    checks++;
    if (epc !== 16'h0040) begin failures++; $display("FAIL rti_epc: got %h want 0040", epc); end
  endtask

  task automatic test_ras_overflow();
    logic [W-1:0] exp_ret;
    drive(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b1, 16'(16'h0300 + i * 16'h0100), 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ras_full !== 1'b1) begin failures++; $display("FAIL ovf_full: got %b want 1", ras_full); end
    checks++;
    if (ras_err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b want 1", ras_err); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_ret = 16'(16'h0602 - i * 16'h0100);
      checks++;
      if (pc !== exp_ret) begin failures++; $display("FAIL ovf_pop%0d: got %h want %h", i, pc, exp_ret); end
    end
    checks++;
    if (ras_empty !== 1'b1) begin failures++; $display("FAIL ovf_drained: got %b want 1", ras_empty); end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0304) begin failures++; $display("FAIL ovf_pop_empty: got %h want 0304", pc); end
    checks++;
    if (ras_err !== 1'b1) begin failures++; $display("FAIL ovf_err_sticky: got %b want 1", ras_err); end
  endtask

  task automatic test_wrap_stall();
    drive(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc_inc !== 16'h0000) begin failures++; $display("FAIL wrap_inc: got %h want 0000", pc_inc); end
    idle();
    checks++;
    if (pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc: got %h want 0000", pc); end
    drive(1'b0, 1'b1, 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0050) begin failures++; $display("FAIL stall_pop_pc: got %h want 0050", pc); end
    checks++;
    if (ras_empty !== 1'b0) begin failures++; $display("FAIL stall_pop_ras: got %b want 0", ras_empty); end
    drive(1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0080) begin failures++; $display("FAIL pushpop_pc: got %h want 0080", pc); end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0052) begin failures++; $display("FAIL pushpop_ret1: got %h want 0052", pc); end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 16'h0002) begin failures++; $display("FAIL pushpop_ret2: got %h want 0002", pc); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 0; redirect = 1; target = 16'h0777; push = 1; pop = 0; exc = 0; rti = 0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (pc !== 16'h0000) begin failures++; $display("FAIL areset_pc: got %h want 0000", pc); end
    checks++;
    if ({ras_empty, ras_full, ras_err} !== 3'b100)
      begin failures++; $display("FAIL areset_flags: got %b want 100", {ras_empty, ras_full, ras_err}); end
    checks++;
    if (epc !== 16'h0000) begin failures++; $display("FAIL areset_epc: got %h want 0000", epc); end
    #1 rst = 1'b0;
    model_reset();
    idle();
    checks++;
    if (pc !== 16'h0002) begin failures++; $display("FAIL areset_first: got %h want 0002", pc); end
  endtask

  task automatic test_random();
    logic s, r, pu, po, e, ri;
    logic [W-1:0] t;
    for (int n = 0; n < 400; n++) begin
      e  = ($urandom_range(0, 19) == 0);
      ri = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 4) == 0);
      pu = $urandom_range(0, 1);
      s  = ($urandom_range(0, 5) == 0);
      po = ($urandom_range(0, 3) == 0);
      t  = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      drive(s, r, t, pu, po, e, ri);
      checks++;
      if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
      checks++;
      if (pc_inc !== 16'(m_pc + 16'd2))
        begin failures++; $display("FAIL rnd_inc[%0d]: got %h want %h", n, pc_inc, 16'(m_pc + 16'd2)); end
      checks++;
      if (epc !== m_epc) begin failures++; $display("FAIL rnd_epc[%0d]: got %h want %h", n, epc, m_epc); end
      checks++;
      if (ras_empty !== (m_ras.size() == 0))
        begin failures++; $display("FAIL rnd_empty[%0d]: got %b size %0d", n, ras_empty, m_ras.size()); end
      checks++;
      if (ras_full !== (m_ras.size() == 4))
        begin failures++; $display("FAIL rnd_full[%0d]: got %b size %0d", n, ras_full, m_ras.size()); end
      checks++;
      if (ras_err !== m_err) begin failures++; $display("FAIL rnd_err[%0d]: got %b want %b", n, ras_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_return();
    test_exception();
    test_ras_overflow();
    test_wrap_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
